tlul_racl_tagger: RTL and testbench
===================================

// Module: tlul_racl_tagger
// PURPOSE
// - Host-side (initiator) counterpart of RACL checking: stamps the RACL role and CTN UID into
//   a_user.rsvd of every outgoing TL-UL request. Device-side checkers recover them with
//   tlul_extract_racl_role_bits / tlul_extract_ctn_uid_bits.
// - Sits between one bus host and its crossbar port. Provides a 1-cycle A-channel register
//   slice, an outstanding-transaction limiter and drain-safe role switching.
// PARAMETERS
// - DefaultRole     top_racl_pkg::racl_role_t  '0  role loaded at reset
// - CtnUid          top_racl_pkg::ctn_uid_t    '0  static CTN UID of this host
// - MaxOutstanding  int unsigned               4   max A requests without D response (>=1)
// PORTS
// - clk_i          in   1         clock
// - rst_i          in   1         synchronous, active-high reset
// - tl_h_i         in   tl_h2d_t  request from host
// - tl_h_o         out  tl_d2h_t  response to host
// - tl_d_o         out  tl_h2d_t  tagged request to crossbar
// - tl_d_i         in   tl_d2h_t  response from crossbar
// - role_req_valid_i in 1         one-cycle request to change role
// - role_req_i     in   NrRaclBits  requested role
// - role_ack_o     out  1         one-cycle pulse when the new role takes effect
// - role_o         out  NrRaclBits  role currently stamped
// - busy_o         out  1         slice non-empty, outstanding != 0, or FSM not IDLE
// - err_o          out  1         sticky: D handshake seen while outstanding == 0
// Interface: one clock; reset is synchronous and active-high (clk_i, rst_i).
// BEHAVIOUR
// - Reset values: role_o=DefaultRole; role_ack_o=0; err_o=0; busy_o=0; slice empty
//   (tl_d_o.a_valid=0); outstanding=0; FSM=IDLE.
// - A path: two-entry skid slice. tl_h_o.a_ready is driven from a flop (slice not full and
//   FSM==IDLE). Latency is 1 cycle from host handshake to tl_d_o.a_valid. Order is preserved.
// - Stamping happens at slice entry: rsvd is written via tlul_insert_racl_bits(rsvd, role_q,
//   CtnUid). All other A fields pass bit-exact. Integrity fields are regenerated by the
//   downstream tlul_cmd_intg_gen, not here.
// - Downstream issue: tl_d_o.a_valid = slice_nonempty && (outstanding < MaxOutstanding).
//   Once valid is asserted it stays asserted until tl_d_i.a_ready.
// - Counter: width $clog2(MaxOutstanding+1).
//   - +1 on the downstream A handshake.
//   - -1 on the host D handshake (tl_h_o.d_valid && tl_h_i.d_ready).
//   - A simultaneous +1 and -1 leaves it unchanged.
//   - A decrement at 0 holds the counter at 0 and sets err_o.
// - D path: combinational passthrough; tl_h_o.d_* = tl_d_i.d_*; tl_d_o.d_ready = tl_h_i.d_ready.
// - Role FSM:
//   - IDLE -> DRAIN on role_req_valid_i; pending_q <= role_req_i.
//   - DRAIN: host a_ready is forced to 0 from the next cycle. A new role_req_valid_i
//     overwrites pending_q and the FSM stays in DRAIN.
//   - DRAIN -> APPLY when the slice is empty, outstanding==0 and no request arrives that cycle.
//   - APPLY: role_q <= pending_q; role_ack_o=1 for this single cycle; -> IDLE. Host a_ready
//     reopens the following cycle.
//   - A request equal to role_q still runs the full drain and ack.
// - A request accepted in the same cycle as role_req_valid_i is stamped with the old role.
// - Reset mid-operation: all state returns to reset values in one cycle and slice contents
//   are discarded. The system resets host and crossbar together, so responses still in
//   flight are not expected.
// STRUCTURE
// - top_racl_pkg gains:
//   - constants RaclRoleLsb=0 and CtnUidLsb=NrRaclBits;
//   - function tlul_insert_racl_bits(rsvd, role, uid), the exact inverse of the extract
//     functions, which are updated to use these LSB constants;
//   - typedef tagger_state_e {IDLE, DRAIN, APPLY}.
// - One sub-module: tlul_racl_skid (2-entry tl_h2d_t skid slice, valid/ready, flopped ready).
// - Counter and FSM stay in the top module.
// TESTING
// - Reset, DefaultRole=0, CtnUid=1; host issues Get at 0x1000 -> tl_d_o.a_valid exactly
//   1 cycle later, role field 0, uid field 1, address 0x1000 unchanged.
// - MaxOutstanding=4, crossbar a_ready=1, d_valid withheld; 6 back-to-back Gets -> exactly 4
//   downstream handshakes, a_valid held high, busy_o=1. Release one D -> 5th request issues
//   the next cycle.
// - 3 requests outstanding; role_req_valid_i pulse with role 1 -> host a_ready=0 until all 3
//   D responses return, then role_ack_o pulses once, role_o=1, next request is stamped role 1.
// - Two role requests (1, then 0) during DRAIN -> a single ack, role_o=0.
// - Downstream a_ready toggled 1/0 per cycle for 10 requests -> all 10 delivered in order,
//   payloads bit-exact except the rsvd tag.
// - Spurious D with outstanding 0 -> err_o=1 and sticky, counter stays 0. rst_i asserted with
//   2 requests in the slice -> next cycle a_valid=0, err_o=0, role_o=DefaultRole.

Source files
------------

// File: rtl/tlul_racl_tagger_pkg.sv
// Shared types for the RACL tagger slice: TL-UL channel structs, RACL role / CTN UID
// field placement inside a_user.rsvd, and the role-switch FSM state encoding.
package tlul_racl_tagger_pkg;

  localparam int unsigned NrRaclBits   = 4;
  localparam int unsigned NrCtnUidBits = 8;
  localparam int unsigned RsvdW        = 16;

  // Role sits in the low bits of rsvd, the CTN UID directly above it.
  localparam int unsigned RaclRoleLsb = 0;
  localparam int unsigned CtnUidLsb   = NrRaclBits;

  typedef logic [NrRaclBits-1:0]   racl_role_t;
  typedef logic [NrCtnUidBits-1:0] ctn_uid_t;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic [RsvdW-1:0] rsvd;
    logic [3:0]       instr_type;
    logic [6:0]       cmd_intg;
    logic [6:0]       data_intg;
  } tl_a_user_t;

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    tl_a_user_t  a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [0:0]  d_sink;
    logic [31:0] d_data;
    tl_d_user_t  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    APPLY = 2'd2
  } tagger_state_e;

  function automatic racl_role_t tlul_extract_racl_role_bits(input logic [RsvdW-1:0] rsvd);
    return rsvd[RaclRoleLsb +: NrRaclBits];
  endfunction

  function automatic ctn_uid_t tlul_extract_ctn_uid_bits(input logic [RsvdW-1:0] rsvd);
    return rsvd[CtnUidLsb +: NrCtnUidBits];
  endfunction

  // Inverse of the two extract functions; rsvd bits outside both fields are kept.
  function automatic logic [RsvdW-1:0] tlul_insert_racl_bits(input logic [RsvdW-1:0] rsvd,
                                                             input racl_role_t        role,
                                                             input ctn_uid_t          uid);
    logic [RsvdW-1:0] res;
    res = rsvd;
    res[RaclRoleLsb +: NrRaclBits] = role;
    res[CtnUidLsb +: NrCtnUidBits] = uid;
    return res;
  endfunction

endpackage

// File: rtl/tlul_racl_skid.sv
// Two-entry A-channel skid slice. Upstream ready comes from a flop so the host never sees
// a combinational path from the crossbar; in_allow_i lets the owner close the input.
module tlul_racl_skid
  import tlul_racl_tagger_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    in_valid_i,
  input  tl_h2d_t in_data_i,
  output logic    in_ready_o,
  input  logic    in_allow_i,
  output logic    out_valid_o,
  output tl_h2d_t out_data_o,
  input  logic    out_ready_i
);

  tl_h2d_t    mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       ready_q;
  logic       push;
  logic       pop;

  assign push = in_valid_i && ready_q;
  assign pop  = out_ready_i && (count_q != 2'd0);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Ready is computed from next-cycle occupancy and next-cycle FSM state, so it is exact.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      ready_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
      ready_q <= (count_d != 2'd2) && in_allow_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= in_data_i;
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/tlul_racl_tagger.sv
// Host-side RACL tagger: stamps role and CTN UID into a_user.rsvd, limits outstanding
// requests, and switches role only once the host's traffic has fully drained.
module tlul_racl_tagger
  import tlul_racl_tagger_pkg::*;
#(
  parameter racl_role_t  DefaultRole    = '0,
  parameter ctn_uid_t    CtnUid         = '0,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  tl_h2d_t       tl_h_i,
  output tl_d2h_t       tl_h_o,
  output tl_h2d_t       tl_d_o,
  input  tl_d2h_t       tl_d_i,
  input  logic          role_req_valid_i,
  input  racl_role_t    role_req_i,
  output logic          role_ack_o,
  output racl_role_t    role_o,
  output logic          busy_o,
  output logic          err_o,
  output tagger_state_e state_o
);

  localparam int unsigned    CntW   = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  tagger_state_e   state_q;
  tagger_state_e   state_d;
  racl_role_t      role_q;
  racl_role_t      pending_q;
  logic [CntW-1:0] out_cnt_q;
  logic            err_q;

  tl_h2d_t stamped;
  tl_h2d_t slice_head;
  logic    slice_valid;
  logic    host_a_ready;
  logic    issue_ok;
  logic    a_hs;
  logic    d_hs;

  // Stamping at slice entry means the role is fixed at the moment the host handshakes.
  always_comb begin
    stamped = tl_h_i;
    stamped.a_user.rsvd = tlul_insert_racl_bits(tl_h_i.a_user.rsvd, role_q, CtnUid);
  end

  tlul_racl_skid u_skid (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (tl_h_i.a_valid),
    .in_data_i   (stamped),
    .in_ready_o  (host_a_ready),
    .in_allow_i  (state_d == IDLE),
    .out_valid_o (slice_valid),
    .out_data_o  (slice_head),
    .out_ready_i (tl_d_i.a_ready && issue_ok)
  );

  // Outstanding only grows on an A handshake, so a raised a_valid cannot drop before ready.
  assign issue_ok = (out_cnt_q < MaxCnt);

  always_comb begin
    tl_d_o         = slice_head;
    tl_d_o.a_valid = slice_valid && issue_ok;
    tl_d_o.d_ready = tl_h_i.d_ready;
  end

  always_comb begin
    tl_h_o         = tl_d_i;
    tl_h_o.a_ready = host_a_ready;
  end

  assign a_hs = tl_d_o.a_valid && tl_d_i.a_ready;
  assign d_hs = tl_h_o.d_valid && tl_h_i.d_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (d_hs && (out_cnt_q == '0)) err_q <= 1'b1;
      if (a_hs && !d_hs) begin
        out_cnt_q <= out_cnt_q + CntOne;
      end else if (d_hs && !a_hs && (out_cnt_q != '0)) begin
        out_cnt_q <= out_cnt_q - CntOne;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (role_req_valid_i) state_d = DRAIN;
      DRAIN: if (!role_req_valid_i && !slice_valid && (out_cnt_q == '0)) state_d = APPLY;
      APPLY: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A role request arriving during the single APPLY cycle is not captured.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      role_q    <= DefaultRole;
      pending_q <= DefaultRole;
    end else begin
      state_q <= state_d;
      if (role_req_valid_i && (state_q != APPLY)) pending_q <= role_req_i;
      if (state_q == APPLY) role_q <= pending_q;
    end
  end

  assign role_ack_o = (state_q == APPLY);
  assign role_o     = role_q;
  assign busy_o     = slice_valid || (out_cnt_q != '0) || (state_q != IDLE);
  assign err_o      = err_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_tlul_racl_tagger.sv
// Directed bench for tlul_racl_tagger: stamping, latency, outstanding limit, role drain,
// back-pressure ordering, spurious-D error and mid-operation reset.
module tb_tlul_racl_tagger;
  import tlul_racl_tagger_pkg::*;

  localparam int W = $bits(tl_h2d_t);

  logic          clk = 1'b0;
  logic          rst;
  tl_h2d_t       tl_h_i;
  tl_d2h_t       tl_h_o;
  tl_h2d_t       tl_d_o;
  tl_d2h_t       tl_d_i;
  logic          role_req_valid;
  racl_role_t    role_req;
  logic          role_ack;
  racl_role_t    role;
  logic          busy;
  logic          err;
  tagger_state_e state;

  int n_checks = 0;
  int n_fail   = 0;
  int n_issued = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  tlul_racl_tagger #(
    .DefaultRole   (4'h0),
    .CtnUid        (8'h01),
    .MaxOutstanding(4)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .tl_h_i          (tl_h_i),
    .tl_h_o          (tl_h_o),
    .tl_d_o          (tl_d_o),
    .tl_d_i          (tl_d_i),
    .role_req_valid_i(role_req_valid),
    .role_req_i      (role_req),
    .role_ack_o      (role_ack),
    .role_o          (role),
    .busy_o          (busy),
    .err_o           (err),
    .state_o         (state)
  );

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic tl_h2d_t norm(input tl_h2d_t p);
    p.d_ready = 1'b0;
    return p;
  endfunction

  // Expected downstream beat: role in rsvd[3:0], uid 0x01 in rsvd[11:4], rest untouched.
  function automatic tl_h2d_t expect_pkt(input tl_h2d_t p, input racl_role_t r);
    p.a_user.rsvd = {p.a_user.rsvd[15:12], 8'h01, r};
    p.a_valid     = 1'b1;
    p.d_ready     = 1'b0;
    return p;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && tl_d_o.a_valid && tl_d_i.a_ready) begin
      n_issued++;
      check("issue_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) check("issue_pkt", norm(tl_d_o), exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] mask, input logic [15:0] rsvd, input racl_role_t exp_role);
    tl_h2d_t p;
    p                     = '0;
    p.a_valid             = 1'b1;
    p.a_opcode            = op;
    p.a_param             = 3'h0;
    p.a_size              = 2'd2;
    p.a_source            = addr[9:2];
    p.a_address           = addr;
    p.a_mask              = mask;
    p.a_data              = data;
    p.a_user.rsvd         = rsvd;
    p.a_user.instr_type   = 4'h9;
    p.a_user.cmd_intg     = addr[6:0] ^ 7'h55;
    p.a_user.data_intg    = data[6:0];
    p.d_ready             = 1'b1;
    tl_h_i = p;
    for (int k = 0; k < 100 && !tl_h_o.a_ready; k++) begin
      @(posedge clk);
      #1;
    end
    check("send_accept", tl_h_o.a_ready, 1'b1);
    if (tl_h_o.a_ready) begin
      exp_q.push_back(expect_pkt(p, exp_role));
      @(posedge clk);
      #1;
    end
    tl_h_i.a_valid = 1'b0;
  endtask

  task automatic d_resp(input logic [31:0] data);
    tl_d_i.d_valid  = 1'b1;
    tl_d_i.d_opcode = AccessAckData;
    tl_d_i.d_data   = data;
    @(posedge clk);
    #1;
    tl_d_i.d_valid = 1'b0;
  endtask

  task automatic count_acks(input int n, output int acks);
    acks = 0;
    for (int k = 0; k < n; k++) begin
      mid();
      if (role_ack) acks++;
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    int acks;
    int n_ret;

    rst            = 1'b1;
    tl_h_i         = '0;
    tl_h_i.d_ready = 1'b1;
    tl_d_i         = '0;
    role_req_valid = 1'b0;
    role_req       = '0;
    cyc(3);
    rst = 1'b0;

    // Reset state
    mid();
    check("rst_role", role, 4'h0);
    check("rst_ack", role_ack, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_a_valid", tl_d_o.a_valid, 1'b0);
    check("rst_a_ready", tl_h_o.a_ready, 1'b1);
    check("rst_state", state, IDLE);

    // Single Get: 1-cycle latency and stamping
    @(posedge clk); #1;
    send(Get, 32'h0000_1000, 32'h0, 4'hF, 16'hABCD, 4'h0);
    mid();
    check("t1_latency_valid", tl_d_o.a_valid, 1'b1);
    check("t1_role_field", tl_d_o.a_user.rsvd[3:0], 4'h0);
    check("t1_uid_field", tl_d_o.a_user.rsvd[11:4], 8'h01);
    check("t1_address", tl_d_o.a_address, 32'h0000_1000);
    @(posedge clk); #1;
    tl_d_i.a_ready = 1'b1;
    cyc(1);
    tl_d_i.d_valid  = 1'b1;
    tl_d_i.d_opcode = AccessAckData;
    tl_d_i.d_data   = 32'hCAFE_0001;
    mid();
    check("t1_d_valid_pass", tl_h_o.d_valid, 1'b1);
    check("t1_d_data_pass", tl_h_o.d_data, 32'hCAFE_0001);
    check("t1_d_ready_pass", tl_d_o.d_ready, 1'b1);
    @(posedge clk); #1;
    tl_d_i.d_valid = 1'b0;
    mid();
    check("t1_idle_busy", busy, 1'b0);
    check("t1_no_err", err, 1'b0);

    // Outstanding limit: 6 Gets, D withheld
    @(posedge clk); #1;
    base = n_issued;
    for (int i = 0; i < 6; i++) send(Get, 32'h3000 + 32'(i * 4), 32'h0, 4'hF, 16'h0000, 4'h0);
    cyc(3);
    mid();
    check("t2_issued_4", n_issued - base, 4);
    check("t2_limit_blocks", tl_d_o.a_valid, 1'b0);
    check("t2_busy", busy, 1'b1);
    check("t2_slice_full", tl_h_o.a_ready, 1'b0);
    @(posedge clk); #1;
    tl_d_i.d_valid = 1'b1;
    mid();
    check("t2_still_blocked", tl_d_o.a_valid, 1'b0);
    @(posedge clk); #1;
    tl_d_i.d_valid = 1'b0;
    mid();
    check("t2_fifth_valid", tl_d_o.a_valid, 1'b1);
    check("t2_issued_5", n_issued - base, 5);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      d_resp(32'h0);
      cyc(1);
    end
    cyc(2);
    mid();
    check("t2_issued_6", n_issued - base, 6);
    check("t2_drained", busy, 1'b0);
    check("t2_queue_empty", exp_q.size(), 0);

    // Role switch with 3 outstanding
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) send(Get, 32'h4000 + 32'(i * 4), 32'h0, 4'hF, 16'h0000, 4'h0);
    cyc(2);
    role_req_valid = 1'b1;
    role_req       = 4'h1;
    @(posedge clk); #1;
    role_req_valid = 1'b0;
    mid();
    check("t3_ready_closed", tl_h_o.a_ready, 1'b0);
    check("t3_state_drain", state, DRAIN);
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      d_resp(32'h0);
      mid();
      check("t3_drain_ready", tl_h_o.a_ready, 1'b0);
      check("t3_drain_no_ack", role_ack, 1'b0);
      check("t3_drain_state", state, DRAIN);
    end
    @(posedge clk); #1;
    mid();
    check("t3_ack", role_ack, 1'b1);
    check("t3_apply_state", state, APPLY);
    check("t3_apply_old_role", role, 4'h0);
    check("t3_apply_ready", tl_h_o.a_ready, 1'b0);
    @(posedge clk); #1;
    mid();
    check("t3_ack_single", role_ack, 1'b0);
    check("t3_new_role", role, 4'h1);
    check("t3_ready_reopen", tl_h_o.a_ready, 1'b1);
    check("t3_state_idle", state, IDLE);
    @(posedge clk); #1;
    send(Get, 32'h0000_4100, 32'h0, 4'hF, 16'h5555, 4'h1);
    cyc(2);
    d_resp(32'h0);
    cyc(1);

    // Two role requests during DRAIN (1 then 0)
    send(Get, 32'h0000_5000, 32'h0, 4'hF, 16'h0000, 4'h1);
    cyc(2);
    role_req_valid = 1'b1;
    role_req       = 4'h1;
    @(posedge clk); #1;
    role_req = 4'h0;
    @(posedge clk); #1;
    role_req_valid = 1'b0;
    d_resp(32'h0);
    count_acks(8, acks);
    check("t4_single_ack", acks, 1);
    check("t4_last_role", role, 4'h0);

    // Request accepted in the same cycle as the role request keeps the old role
    role_req_valid = 1'b1;
    role_req       = 4'h1;
    send(Get, 32'h0000_6000, 32'h0, 4'hF, 16'h0000, 4'h0);
    role_req_valid = 1'b0;
    cyc(2);
    d_resp(32'h0);
    count_acks(8, acks);
    check("t4b_ack", acks, 1);
    check("t4b_role", role, 4'h1);

    // Request equal to current role still acks
    role_req_valid = 1'b1;
    role_req       = 4'h1;
    @(posedge clk); #1;
    role_req_valid = 1'b0;
    count_acks(8, acks);
    check("t4c_same_role_ack", acks, 1);
    check("t4c_role", role, 4'h1);

    // Toggling downstream ready, 10 writes, D returned as they issue
    base  = n_issued;
    n_ret = 0;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(PutFullData, 32'h7000 + 32'(i * 8), 32'hA5A5_0000 | 32'(i), 4'(i) | 4'h1,
               {4'(i), 12'hFFF}, 4'h1);
      end
      begin
        for (int k = 0; k < 300 && (n_issued - base) < 10; k++) begin
          @(posedge clk); #1;
          tl_d_i.a_ready = ~tl_d_i.a_ready;
        end
        tl_d_i.a_ready = 1'b1;
      end
      begin
        for (int k = 0; k < 300 && n_ret < 10; k++) begin
          @(posedge clk); #1;
          if ((n_issued - base) > n_ret) begin
            tl_d_i.d_valid = 1'b1;
            n_ret++;
          end else begin
            tl_d_i.d_valid = 1'b0;
          end
        end
        @(posedge clk); #1;
        tl_d_i.d_valid = 1'b0;
      end
    join
    cyc(2);
    mid();
    check("t5_delivered", n_issued - base, 10);
    check("t5_queue_empty", exp_q.size(), 0);
    check("t5_idle", busy, 1'b0);
    check("t5_no_err", err, 1'b0);

    // Spurious D with nothing outstanding
    @(posedge clk); #1;
    d_resp(32'h0);
    mid();
    check("t6_err_set", err, 1'b1);
    check("t6_cnt_zero", busy, 1'b0);
    cyc(3);
    mid();
    check("t6_err_sticky", err, 1'b1);
    @(posedge clk); #1;
    base = n_issued;
    send(Get, 32'h0000_8000, 32'h0, 4'hF, 16'h0000, 4'h1);
    cyc(2);
    check("t6_issue_after_err", n_issued - base, 1);
    d_resp(32'h0);

    // Reset with two requests parked in the slice
    tl_d_i.a_ready = 1'b0;
    send(Get, 32'h0000_9000, 32'h0, 4'hF, 16'h0000, 4'h1);
    send(Get, 32'h0000_9004, 32'h0, 4'hF, 16'h0000, 4'h1);
    mid();
    check("t7_pre_valid", tl_d_o.a_valid, 1'b1);
    check("t7_pre_busy", busy, 1'b1);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mid();
    check("t7_a_valid", tl_d_o.a_valid, 1'b0);
    check("t7_err", err, 1'b0);
    check("t7_role", role, 4'h0);
    check("t7_busy", busy, 1'b0);
    check("t7_a_ready", tl_h_o.a_ready, 1'b1);
    check("t7_state", state, IDLE);
    @(posedge clk); #1;
    tl_d_i.a_ready = 1'b1;
    base = n_issued;
    send(Get, 32'h0000_A000, 32'h0, 4'hF, 16'h0000, 4'h0);
    cyc(2);
    check("t7_post_issue", n_issued - base, 1);
    d_resp(32'h0);
    mid();
    check("t7_final_idle", busy, 1'b0);
    check("t7_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
